// File: rtl/ex_pkg.sv
// Shared definitions for the execute-stage core: widths, ALU opcodes, dest selects.
package ex_pkg;

  localparam int unsigned EX_WIDTH = 32;
  localparam int unsigned EX_RAW   = 5;
  localparam int unsigned EX_LINK  = 31;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned DST_SEL_W = 2;

  // ALU operation encodings
  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_NOR   = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'b1001;
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'b1010;
  localparam logic [ALU_OP_W-1:0] ALU_LUI   = 4'b1011;
  localparam logic [ALU_OP_W-1:0] ALU_LINK  = 4'b1100;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'b1101;

  // Destination register select encodings
  localparam logic [DST_SEL_W-1:0] DST_RT   = 2'b00;
  localparam logic [DST_SEL_W-1:0] DST_RD   = 2'b01;
  localparam logic [DST_SEL_W-1:0] DST_LINK = 2'b10;
  localparam logic [DST_SEL_W-1:0] DST_ZERO = 2'b11;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU for the execute stage; shift amount is the low log2(WIDTH) bits of op_b.
module ex_alu
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = EX_WIDTH
) (
  input  logic [WIDTH-1:0]    op_a,
  input  logic [WIDTH-1:0]    op_b,
  input  logic [ALU_OP_W-1:0] op_sel,
  output logic [WIDTH-1:0]    result_c
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] sh;
  logic            lt_s;
  logic            lt_u;

  assign sh   = op_b[SH_W-1:0];
  assign lt_s = $signed(op_a) < $signed(op_b);
  assign lt_u = op_a < op_b;

  // Operation decode; unused encodings produce zero
  always_comb begin
    result_c = '0;
    unique case (op_sel)
      ALU_ADD:   result_c = op_a + op_b;
      ALU_SUB:   result_c = op_a - op_b;
      ALU_AND:   result_c = op_a & op_b;
      ALU_OR:    result_c = op_a | op_b;
      ALU_XOR:   result_c = op_a ^ op_b;
      ALU_NOR:   result_c = ~(op_a | op_b);
      ALU_SLT:   result_c = WIDTH'(lt_s);
      ALU_SLTU:  result_c = WIDTH'(lt_u);
      ALU_SLL:   result_c = op_a << sh;
      ALU_SRL:   result_c = op_a >> sh;
      ALU_SRA:   result_c = WIDTH'($signed(op_a) >>> sh);
      ALU_LUI:   result_c = op_b << 16;
      ALU_LINK:  result_c = op_a + WIDTH'(4);
      ALU_PASSB: result_c = op_b;
      default:   result_c = '0;
    endcase
  end

endmodule

// File: rtl/ex_unit_core.sv
// Execute-stage core: ALU, destination selector and branch compare, all registered once.
module ex_unit_core
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH    = EX_WIDTH,
  parameter int unsigned RAW      = EX_RAW,
  parameter int unsigned LINK_REG = EX_LINK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op_sel,
  input  logic [WIDTH-1:0] cmp_a,
  input  logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_ne,
  input  logic [RAW-1:0]   rt,
  input  logic [RAW-1:0]   rd,
  input  logic [1:0]       dst_sel,
  output logic [WIDTH-1:0] alu_result,
  output logic [RAW-1:0]   dst_reg,
  output logic             br_taken,
  output logic             valid_out
);

  logic [WIDTH-1:0] alu_res_c;
  logic [RAW-1:0]   dst_c;
  logic             eq_c;

  logic [WIDTH-1:0] alu_result_d, alu_result_q;
  logic [RAW-1:0]   dst_reg_d,    dst_reg_q;
  logic             br_taken_d,   br_taken_q;
  logic             valid_out_d,  valid_out_q;

  ex_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op_a     (op_a),
    .op_b     (op_b),
    .op_sel   (op_sel),
    .result_c (alu_res_c)
  );

  // Destination register selection
  always_comb begin
    dst_c = '0;
    unique case (dst_sel)
      DST_RT:   dst_c = rt;
      DST_RD:   dst_c = rd;
      DST_LINK: dst_c = RAW'(LINK_REG);
      DST_ZERO: dst_c = '0;
      default:  dst_c = '0;
    endcase
  end

  assign eq_c = (cmp_a == cmp_b);

  // Next-state: load fresh results when enabled, otherwise hold (stall)
  always_comb begin
    alu_result_d = alu_result_q;
    dst_reg_d    = dst_reg_q;
    br_taken_d   = br_taken_q;
    valid_out_d  = valid_out_q;
    if (en) begin
      alu_result_d = alu_res_c;
      dst_reg_d    = dst_c;
      br_taken_d   = cmp_ne ? ~eq_c : eq_c;
      valid_out_d  = valid_in;
    end
  end

  // Output registers; synchronous reset overrides enable
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_q <= '0;
      dst_reg_q    <= '0;
      br_taken_q   <= 1'b0;
      valid_out_q  <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      dst_reg_q    <= dst_reg_d;
      br_taken_q   <= br_taken_d;
      valid_out_q  <= valid_out_d;
    end
  end

  assign alu_result = alu_result_q;
  assign dst_reg    = dst_reg_q;
  assign br_taken   = br_taken_q;
  assign valid_out  = valid_out_q;

endmodule

// File: tb/tb_ex_unit_core.sv
// Self-checking bench for ex_unit_core: behavioural reference model plus directed literal checks.
module tb_ex_unit_core;

  logic        clk = 1'b0;
  logic        rst, en, valid_in, cmp_ne;
  logic [31:0] op_a, op_b, cmp_a, cmp_b;
  logic [3:0]  op_sel;
  logic [4:0]  rt, rd;
  logic [1:0]  dst_sel;
  logic [31:0] alu_result;
  logic [4:0]  dst_reg;
  logic        br_taken, valid_out;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] e_alu;
  logic [4:0]  e_dst;
  logic        e_br, e_v;
  bit          ref_ok = 0;

  always #5 clk = ~clk;

  ex_unit_core dut (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_ne(cmp_ne),
    .rt(rt), .rd(rd), .dst_sel(dst_sel),
    .alu_result(alu_result), .dst_reg(dst_reg),
    .br_taken(br_taken), .valid_out(valid_out)
  );

  function automatic logic [31:0] alu_model(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ~(a | b);
      6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      7:  return (a < b) ? 32'd1 : 32'd0;
      8:  return a << sh;
      9:  return a >> sh;
      10: return 32'($signed(a) >>> sh);
      11: return b * 32'd65536;
      12: return a + 32'd4;
      13: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [4:0] dst_model(input int sel, input logic [4:0] t, input logic [4:0] d);
    case (sel)
      0: return t;
      1: return d;
      2: return 5'd31;
      default: return 5'd0;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model advances on each rising edge; outputs checked 1 time unit later
  initial begin
    forever begin
      @(posedge clk);
      if (rst === 1'b1) begin
        e_alu = 32'd0; e_dst = 5'd0; e_br = 1'b0; e_v = 1'b0;
        ref_ok = 1;
      end else if (en === 1'b1 && ref_ok) begin
        e_alu = alu_model(int'(op_sel), op_a, op_b);
        e_dst = dst_model(int'(dst_sel), rt, rd);
        e_br  = (cmp_a == cmp_b) ^ cmp_ne;
        e_v   = valid_in;
      end
      #1;
      if (ref_ok) begin
        cmp("model_alu", alu_result, e_alu);
        cmp("model_dst", 32'(dst_reg), 32'(e_dst));
        cmp("model_br", 32'(br_taken), 32'(e_br));
        cmp("model_valid", 32'(valid_out), 32'(e_v));
      end
    end
  end

  task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    op_sel = op; op_a = a; op_b = b;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic alu_lit(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    set_alu(op, a, b);
    tick();
    cmp(name, alu_result, exp);
  endtask

  initial begin
    // Reset with nonzero inputs
    rst = 1; en = 1; valid_in = 1;
    set_alu(4'd0, 32'h1234, 32'h5678);
    cmp_a = 32'h1; cmp_b = 32'h1; cmp_ne = 0;
    rt = 5'd3; rd = 5'd4; dst_sel = 2'd0;
    tick(); tick();
    cmp("rst_alu", alu_result, 32'd0);
    cmp("rst_dst", 32'(dst_reg), 32'd0);
    cmp("rst_br", 32'(br_taken), 32'd0);
    cmp("rst_valid", 32'(valid_out), 32'd0);

    rst = 0;
    alu_lit("add_5_3", 4'b0000, 32'd5, 32'd3, 32'd8);
    cmp("valid_after_rst", 32'(valid_out), 32'd1);

    // ALU sweep and boundaries
    alu_lit("sub_3_5", 4'b0001, 32'd3, 32'd5, 32'hFFFF_FFFE);
    alu_lit("slt_neg", 4'b0110, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_lit("sltu_big", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_lit("sra_4", 4'b1010, 32'hF000_0000, 32'd4, 32'hFF00_0000);
    alu_lit("lui", 4'b1011, 32'd0, 32'h1234, 32'h1234_0000);
    alu_lit("link", 4'b1100, 32'h400, 32'd0, 32'h404);
    alu_lit("op_1111", 4'b1111, 32'hDEAD, 32'hBEEF, 32'd0);
    alu_lit("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_lit("sub_0_1", 4'b0001, 32'd0, 32'd1, 32'hFFFF_FFFF);
    alu_lit("slt_min", 4'b0110, 32'h8000_0000, 32'd1, 32'd1);
    alu_lit("sltu_min", 4'b0111, 32'h8000_0000, 32'd1, 32'd0);
    alu_lit("sra_31", 4'b1010, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
    alu_lit("sll_32", 4'b1000, 32'hA5A5_0001, 32'd32, 32'hA5A5_0001);
    alu_lit("srl_8", 4'b1001, 32'h8000_0000, 32'd8, 32'h0080_0000);
    alu_lit("nor", 4'b0101, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0F0F_F0F0);
    alu_lit("passb", 4'b1101, 32'd1, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Destination select
    rt = 5'd7; rd = 5'd9;
    dst_sel = 2'd0; tick(); cmp("dst_rt", 32'(dst_reg), 32'd7);
    dst_sel = 2'd1; tick(); cmp("dst_rd", 32'(dst_reg), 32'd9);
    dst_sel = 2'd2; tick(); cmp("dst_link", 32'(dst_reg), 32'd31);
    dst_sel = 2'd3; tick(); cmp("dst_zero", 32'(dst_reg), 32'd0);

    // Branch compare
    cmp_a = 32'h55; cmp_b = 32'h55;
    cmp_ne = 0; tick(); cmp("beq_eq", 32'(br_taken), 32'd1);
    cmp_ne = 1; tick(); cmp("bne_eq", 32'(br_taken), 32'd0);
    cmp_b = 32'h54; tick(); cmp("bne_ne", 32'(br_taken), 32'd1);
    cmp_ne = 0; tick(); cmp("beq_ne", 32'(br_taken), 32'd0);

    // Stall holds outputs
    alu_lit("stall_load", 4'b0000, 32'd1, 32'd1, 32'd2);
    en = 0;
    set_alu(4'b0000, 32'd10, 32'd10);
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("stall_hold", alu_result, 32'd2);
    end
    en = 1;
    tick();
    cmp("stall_release", alu_result, 32'd20);

    // Reset during a stall clears everything
    valid_in = 1;
    alu_lit("pre_rst", 4'b0000, 32'd1, 32'd1, 32'd2);
    en = 0; rst = 1;
    tick();
    cmp("rst_stall_alu", alu_result, 32'd0);
    cmp("rst_stall_valid", 32'(valid_out), 32'd0);
    rst = 0;
    tick();
    cmp("rst_stall_hold", alu_result, 32'd0);
    en = 1;

    // Randomized stimulus against the reference model
    for (int n = 0; n < 2000; n++) begin
      rst      = ($urandom_range(0, 31) == 0);
      en       = ($urandom_range(0, 3) != 0);
      valid_in = 1'($urandom);
      op_sel   = 4'($urandom);
      case ($urandom_range(0, 3))
        0: begin op_a = $urandom; op_b = $urandom; end
        1: begin op_a = $urandom; op_b = 32'($urandom_range(0, 40)); end
        2: begin op_a = 32'h8000_0000 ^ 32'($urandom_range(0, 1)); op_b = 32'hFFFF_FFFF; end
        default: begin op_a = 32'($urandom_range(0, 3)); op_b = 32'($urandom_range(0, 3)); end
      endcase
      cmp_a    = 32'($urandom_range(0, 3));
      cmp_b    = ($urandom_range(0, 1) == 1) ? cmp_a : $urandom;
      cmp_ne   = 1'($urandom);
      rt       = 5'($urandom);
      rd       = 5'($urandom);
      dst_sel  = 2'($urandom);
      tick();
    end

    rst = 0; en = 1;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_unit_core.md
Name: ex_unit_core

Overview:
- Registered execute-stage datapath core for the 5-stage pipeline processor.
- Combines three functions:
  - a 32-bit ALU;
  - a 4-way destination-register selector (rt / rd / link register / r0);
  - a branch-compare unit producing a taken flag.
- Sits between the ID/EX operand muxing (forwarding already resolved upstream) and the EX/MEM boundary. All results are registered once.

Parameters:
- WIDTH, 32, datapath width in bits.
- RAW, 5, register-address width.
- LINK_REG, 31, register index written by link instructions (dst_sel=2).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  register-update enable; 0 holds all outputs (stall).
- valid_in  in  1  instruction in EX is valid.
- op_a  in  WIDTH  ALU operand 1 (register data or PC, pre-selected).
- op_b  in  WIDTH  ALU operand 2 (register data or sign-extended immediate).
- op_sel  in  4  ALU operation select.
- cmp_a  in  WIDTH  branch-compare operand 1 (rs data).
- cmp_b  in  WIDTH  branch-compare operand 2 (rt data).
- cmp_ne  in  1  0 = branch-if-equal, 1 = branch-if-not-equal.
- rt  in  RAW  rt field.
- rd  in  RAW  rd field.
- dst_sel  in  2  destination select.
- alu_result  out  WIDTH  registered ALU result.
- dst_reg  out  RAW  registered destination register index.
- br_taken  out  1  registered branch condition result.
- valid_out  out  1  registered valid.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - On a clk edge with rst=1, all outputs go to 0 regardless of en.
- Registering and latency:
  - Otherwise, if en=1, all four output registers load their next-state values on the edge.
  - If en=0, all outputs hold.
  - Latency is exactly 1 cycle from inputs to outputs. No combinational path from inputs to outputs.
- valid_out:
  - valid_out loads valid_in.
  - Data registers load regardless of valid_in; consumers qualify with valid_out.
- ALU, by op_sel (unsigned wrap for add/sub; shift amount = op_b[4:0]):
  - 0000 ADD: op_a+op_b
  - 0001 SUB: op_a-op_b
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 NOR
  - 0110 SLT: signed op_a<op_b gives 1, else 0, zero-extended
  - 0111 SLTU: unsigned compare
  - 1000 SLL: op_a<<sh
  - 1001 SRL: logical right
  - 1010 SRA: arithmetic right
  - 1011 LUI: op_b<<16
  - 1100 LINK: op_a+4 (return address for JAL)
  - 1101 PASS_B: op_b
  - 1110, 1111: result 0
- Destination select, by dst_sel:
  - 00 → rt
  - 01 → rd
  - 10 → LINK_REG
  - 11 → 0
- Branch compare:
  - eq = (cmp_a==cmp_b), full WIDTH compare.
  - br_taken next = cmp_ne ? ~eq : eq.
  - Computed every cycle; its meaning is the consumer's concern.
- Boundary cases:
  - ADD 0xFFFFFFFF+1 = 0 (no carry out).
  - SUB 0-1 = 0xFFFFFFFF.
  - SLT 0x80000000 vs 1 gives 1; SLTU gives 0.
  - SRA 0x80000000 by 31 gives 0xFFFFFFFF.
  - Shift amount uses only 5 LSBs (op_b=32 shifts by 0).
- Simultaneous events: rst and en both 1 → reset wins. rst during a stall still clears.

Decomposition:
- Shared package (ex_pkg):
  - ALU op_sel localparams (ALU_ADD … ALU_PASSB);
  - dst_sel localparams (DST_RT, DST_RD, DST_LINK, DST_ZERO);
  - WIDTH and RAW defaults.
- One natural combinational sub-module: ex_alu (op_a, op_b, op_sel → result).
- Dest mux and compare stay inline in ex_unit_core together with the output registers.

Test Plan:
- Reset: drive rst=1 for 2 cycles with nonzero inputs and en=1 → all outputs 0. Release: op_a=5, op_b=3, ADD → alu_result=8 one cycle later.
- ALU sweep:
  - SUB 3-5 → 0xFFFFFFFE
  - SLT 0xFFFFFFFF,1 → 1
  - SLTU 0xFFFFFFFF,1 → 0
  - SRA 0xF0000000 by 4 → 0xFF000000
  - LUI op_b=0x1234 → 0x12340000
  - LINK op_a=0x400 → 0x404
  - op_sel 1111 → 0
- Dest select: rt=7, rd=9; dst_sel 00/01/10/11 → dst_reg 7/9/31/0 on successive cycles.
- Branch: cmp_a=cmp_b=0x55.
  - cmp_ne=0 → br_taken=1; cmp_ne=1 → 0.
  - cmp_a=0x55, cmp_b=0x54 with cmp_ne=1 → 1.
- Stall: load ADD 1+1 (result 2), then en=0 with ADD 10+10 for 3 cycles → alu_result stays 2. en=1 → 20 next cycle.
- Reset mid-stall: en=0 holding result 2, assert rst for 1 cycle → all outputs 0 after that edge; valid_out=0.
